// File: rtl/serial_m0_peer_pkg.sv
// Shared state encodings and frame sizing for the mode-0 shift-register peer.
package serial_m0_peer_pkg;

  localparam int unsigned SM0_BITS  = 8;
  localparam int unsigned SM0_CNT_W = 4;

  typedef enum logic [1:0] {
    SM0_IDLE = 2'd0,
    SM0_RX   = 2'd1,
    SM0_TX   = 2'd2
  } sm0_state_e;

endpackage

// File: rtl/serial_m0_sync.sv
// Synchronizes the MCU shift clock and RXD line and flags synced shift-clock rises.
module serial_m0_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic rxd,
  output logic rxd_sync,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] rxd_q;
  logic                   sclk_prev_q;

  // Equal-depth chains keep sampled data aligned with the detected rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q      <= '0;
      rxd_q       <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk};
      rxd_q       <= {rxd_q[SYNC_STAGES-2:0], rxd};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign rxd_sync = rxd_q[SYNC_STAGES-1];
  assign rise_c   = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;

endmodule

// File: rtl/serial_m0_peer.sv
// External responder for the mode-0 synchronous serial link: captures MCU bytes, presents a buffered byte.
// Optional build macro SERIAL_M0_PEER_LOOPBACK_EN auto-loads each received byte into a free tx buffer.
module serial_m0_peer
  import serial_m0_peer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMO_W          = 7
) (
  input  logic       serial_clock_i,
  input  logic       serial_reset_i_b,
  input  logic       serial_m0_sclk_i,
  input  logic       serial_m0_rxd_i,
  input  logic       serial_m0_mcu_oe_i,
  output logic       serial_m0_rxd_o,
  output logic       serial_m0_rxd_oe_o,
  input  logic [7:0] serial_tx_data_i,
  input  logic       serial_tx_load_i,
  output logic       serial_tx_empty_o,
  output logic [7:0] serial_rx_data_o,
  output logic       serial_rx_valid_o,
  output logic       serial_timeout_o
);

  localparam logic [SM0_CNT_W-1:0] LAST_BIT = SM0_CNT_W'(SM0_BITS - 1);
  localparam logic [TMO_W-1:0]     TMO_LIM  = TMO_W'(TIMEOUT_CYCLES - 1);

  logic rxd_sync;
  logic rise_c;

  serial_m0_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (serial_clock_i),
    .rst_n   (serial_reset_i_b),
    .sclk    (serial_m0_sclk_i),
    .rxd     (serial_m0_rxd_i),
    .rxd_sync(rxd_sync),
    .rise_c  (rise_c)
  );

  sm0_state_e           state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [SM0_CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [7:0]           tx_buf_q, tx_buf_d;
  logic                 tx_empty_q, tx_empty_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 timeout_q, timeout_d;

  logic                 abort;
  logic                 rx_done;
  logic                 load_ok;
  logic [7:0]           rx_byte;

  always_ff @(posedge serial_clock_i) begin
    if (!serial_reset_i_b) begin
      state_q    <= SM0_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      tx_buf_q   <= '0;
      tx_empty_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      tx_buf_q   <= tx_buf_d;
      tx_empty_q <= tx_empty_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    tx_buf_d   = tx_buf_q;
    tx_empty_d = tx_empty_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    timeout_d  = 1'b0;
    abort      = 1'b0;
    rx_done    = 1'b0;
    rx_byte    = {rxd_sync, shift_q[6:0]};
    load_ok    = serial_tx_load_i && tx_empty_q && (state_q != SM0_TX);

    case (state_q)
      SM0_IDLE: begin
        cnt_d = '0;
        tmo_d = '0;
        if (serial_m0_mcu_oe_i) begin
          if (rise_c) begin
            shift_d    = '0;
            shift_d[0] = rxd_sync;
            cnt_d      = SM0_CNT_W'(1);
            state_d    = SM0_RX;
          end
        end else if (!tx_empty_q) begin
          shift_d = tx_buf_q;
          state_d = SM0_TX;
        end
      end

      SM0_RX: begin
        if (!serial_m0_mcu_oe_i) begin
          abort = 1'b1;
        end else if (rise_c) begin
          tmo_d                = '0;
          shift_d[cnt_q[2:0]]  = rxd_sync;
          if (cnt_q == LAST_BIT) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
            rx_done    = 1'b1;
            cnt_d      = '0;
            state_d    = SM0_IDLE;
          end else begin
            cnt_d = cnt_q + SM0_CNT_W'(1);
          end
        end else if (tmo_q == TMO_LIM) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      SM0_TX: begin
        // Shift after the MCU has already sampled on its own rising edge.
        if (serial_m0_mcu_oe_i) begin
          abort = 1'b1;
        end else if (rise_c) begin
          tmo_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (cnt_q == LAST_BIT) begin
            tx_empty_d = 1'b1;
            cnt_d      = '0;
            state_d    = SM0_IDLE;
          end else begin
            cnt_d = cnt_q + SM0_CNT_W'(1);
          end
        end else if (tmo_q == TMO_LIM) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: state_d = SM0_IDLE;
    endcase

    // Abort discards partial data but keeps the tx buffer for a restart from bit0.
    if (abort) begin
      state_d   = SM0_IDLE;
      timeout_d = 1'b1;
      cnt_d     = '0;
      tmo_d     = '0;
    end

    if (load_ok) begin
      tx_buf_d   = serial_tx_data_i;
      tx_empty_d = 1'b0;
    end
`ifdef SERIAL_M0_PEER_LOOPBACK_EN
    else if (rx_done && tx_empty_q) begin
      tx_buf_d   = rx_byte;
      tx_empty_d = 1'b0;
    end
`endif
  end

  logic drive_idle_c;
  assign drive_idle_c = (state_q == SM0_IDLE) && !serial_m0_mcu_oe_i && !tx_empty_q;

  assign serial_m0_rxd_oe_o = drive_idle_c || ((state_q == SM0_TX) && !serial_m0_mcu_oe_i);
  assign serial_m0_rxd_o    = (state_q == SM0_TX) ? shift_q[0] :
                              (drive_idle_c ? tx_buf_q[0] : 1'b0);
  assign serial_tx_empty_o  = tx_empty_q;
  assign serial_rx_data_o   = rx_data_q;
  assign serial_rx_valid_o  = rx_valid_q;
  assign serial_timeout_o   = timeout_q;

endmodule

// File: tb/tb_serial_m0_peer.sv
// Scoreboard bench for serial_m0_peer: an MCU model drives the link, monitors check captured bytes and shifted bits.
module tb_serial_m0_peer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       rxd = 1'b0;
  logic       mcu_oe = 1'b1;
  logic       rxd_out;
  logic       rxd_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_empty;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       timeout;

  int         total = 0;
  int         bad = 0;
  int         tmo_hi = 0;
  logic       rv_prev = 1'b0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] exp_rx[$];
  logic       exp_bits[$];

  serial_m0_peer dut (
    .serial_clock_i    (clk),
    .serial_reset_i_b  (rst_n),
    .serial_m0_sclk_i  (sclk),
    .serial_m0_rxd_i   (rxd),
    .serial_m0_mcu_oe_i(mcu_oe),
    .serial_m0_rxd_o   (rxd_out),
    .serial_m0_rxd_oe_o(rxd_oe),
    .serial_tx_data_i  (tx_data),
    .serial_tx_load_i  (tx_load),
    .serial_tx_empty_o (tx_empty),
    .serial_rx_data_o  (rx_data),
    .serial_rx_valid_o (rx_valid),
    .serial_timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Received-byte monitor, sampled on the falling system clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        chk("rx_valid_pulse", {7'd0, rv_prev}, 8'h00);
        if (exp_rx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %h expected no byte", rx_data);
        end else begin
          chk("rx_data", rx_data, exp_rx.pop_front());
        end
      end
      if (timeout) tmo_hi++;
    end
    rv_prev = rx_valid;
  end

  // MCU-side sampler: reads the peer's bit on each rising shift clock while receiving.
  always @(posedge sclk) begin
    if (!mcu_oe) begin
      if (exp_bits.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected_bit: got %b expected none", rxd_out);
      end else begin
        chk("tx_bit", {7'd0, rxd_out}, {7'd0, exp_bits.pop_front()});
        chk("tx_oe", {7'd0, rxd_oe}, 8'h01);
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b);
    rxd = b;
    wait_clks(8);
    sclk = 1'b1;
    wait_clks(8);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    exp_rx.push_back(d);
    last_rx = d;
    for (int i = 0; i < 8; i++) clk_bit(d[i]);
    wait_clks(10);
  endtask

  task automatic push_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) exp_bits.push_back(d[i]);
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    wait_clks(1);
    tx_load = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(1);
    last_rx = 8'h00;
  endtask

  // With loopback built in, each received byte fills the tx buffer; clear it between scenarios.
  task automatic clear_lb();
`ifdef SERIAL_M0_PEER_LOOPBACK_EN
    pulse_reset();
`endif
  endtask

  initial begin
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(1);

    chk("reset_rxd_o", {7'd0, rxd_out}, 8'h00);
    chk("reset_rxd_oe", {7'd0, rxd_oe}, 8'h00);
    chk("reset_tx_empty", {7'd0, tx_empty}, 8'h01);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("reset_timeout", {7'd0, timeout}, 8'h00);

    // MCU shifts 0x55 out.
    mcu_oe = 1'b1;
    send_byte(8'h55);
    chk("rx55_no_timeout", 8'(tmo_hi), 8'h00);
    clear_lb();

    // Peer returns 0xA6.
    load(8'hA6);
    chk("a6_tx_empty_loaded", {7'd0, tx_empty}, 8'h00);
    mcu_oe = 1'b0;
    push_bits(8'hA6, 8);
    wait_clks(2);
    chk("a6_idle_oe", {7'd0, rxd_oe}, 8'h01);
    for (int i = 0; i < 8; i++) clk_bit(1'b0);
    wait_clks(10);
    chk("a6_oe_after", {7'd0, rxd_oe}, 8'h00);
    chk("a6_tx_empty_after", {7'd0, tx_empty}, 8'h01);

    // Partial frame aborted by timeout, then a clean 0xFF.
    mcu_oe = 1'b1;
    for (int i = 0; i < 3; i++) clk_bit(1'b1);
    wait_clks(100);
    chk("tmo_pulse_count", 8'(tmo_hi), 8'h01);
    chk("tmo_rx_data_kept", rx_data, last_rx);
    send_byte(8'hFF);
    chk("ff_no_extra_timeout", 8'(tmo_hi), 8'h01);
    clear_lb();

    // Second load while buffer is full is ignored.
    mcu_oe = 1'b0;
    wait_clks(2);
    load(8'h11);
    wait_clks(1);
    load(8'h22);
    push_bits(8'h11, 8);
    for (int i = 0; i < 8; i++) clk_bit(1'b0);
    wait_clks(10);
    chk("x11_tx_empty_after", {7'd0, tx_empty}, 8'h01);

    // Reset in the middle of a transmit.
    load(8'h5A);
    push_bits(8'h5A, 4);
    for (int i = 0; i < 4; i++) clk_bit(1'b0);
    rst_n = 1'b0;
    wait_clks(1);
    rst_n = 1'b1;
    last_rx = 8'h00;
    chk("midrst_oe", {7'd0, rxd_oe}, 8'h00);
    chk("midrst_tx_empty", {7'd0, tx_empty}, 8'h01);
    chk("midrst_rx_data", rx_data, 8'h00);
    mcu_oe = 1'b1;
    wait_clks(2);
    send_byte(8'h00);

`ifdef SERIAL_M0_PEER_LOOPBACK_EN
    clear_lb();
    mcu_oe = 1'b1;
    send_byte(8'h3C);
    chk("lb_tx_empty", {7'd0, tx_empty}, 8'h00);
    mcu_oe = 1'b0;
    push_bits(8'h3C, 8);
    wait_clks(2);
    for (int i = 0; i < 8; i++) clk_bit(1'b0);
    wait_clks(10);
    chk("lb_tx_empty_after", {7'd0, tx_empty}, 8'h01);
`endif

    for (int i = 0; i < 200 && exp_rx.size() != 0; i++) wait_clks(1);
    chk("rx_queue_drained", 8'(exp_rx.size()), 8'h00);
    chk("bit_queue_drained", 8'(exp_bits.size()), 8'h00);
    chk("final_timeout_count", 8'(tmo_hi), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
